// File: rtl/acc_exec_seq.sv
// Multi-cycle accumulator execution unit: nibble entry, A/B operand latches and a T0/T1/T2 sequencer.
// Define ACC_CHAIN_EN to add the CHAIN input, which feeds AC back as the first operand.
module acc_exec_seq #(
    parameter int WIDTH = 16,
    parameter int OPW   = 3
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [3:0]       NIB_IN,
    input  logic             NIB_SHIFT,
    input  logic             LD1,
    input  logic             LD2,
    input  logic [OPW-1:0]   OP,
    input  logic             START,
`ifdef ACC_CHAIN_EN
    input  logic             CHAIN,
`endif
    output logic [WIDTH-1:0] ENTRY,
    output logic [WIDTH-1:0] AC,
    output logic             BUSY,
    output logic             DONE,
    output logic             OVF,
    output logic             ZERO,
    output logic [3:0]       T
);

    // state | meaning
    // IDLE  | waiting for START
    // T0    | copy operands into working registers
    // T1    | compute (WIDTH cycles for MUL, one otherwise)
    // T2    | write AC and flags
    // DN    | DONE pulse, back to IDLE
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_T0   = 3'd1;
    localparam logic [2:0] S_T1   = 3'd2;
    localparam logic [2:0] S_T2   = 3'd3;
    localparam logic [2:0] S_DN   = 3'd4;

    localparam logic [OPW-1:0] OP_ADD = OPW'(0);
    localparam logic [OPW-1:0] OP_SUB = OPW'(1);
    localparam logic [OPW-1:0] OP_AND = OPW'(2);
    localparam logic [OPW-1:0] OP_OR  = OPW'(3);
    localparam logic [OPW-1:0] OP_XOR = OPW'(4);
    localparam logic [OPW-1:0] OP_SHL = OPW'(5);
    localparam logic [OPW-1:0] OP_MUL = OPW'(6);
    localparam logic [OPW-1:0] OP_CLR = OPW'(7);

    localparam int CW = $clog2(WIDTH);

    logic [2:0]         state;
    logic [WIDTH-1:0]   entry;
    logic [WIDTH-1:0]   reg_a;
    logic [WIDTH-1:0]   reg_b;
    logic [OPW-1:0]     op_r;
    logic [2*WIDTH-1:0] work_a;
    logic [WIDTH-1:0]   work_b;
    logic [2*WIDTH-1:0] prod;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   res_r;
    logic               ovf_r;
    logic [WIDTH-1:0]   ac;
    logic               ovf;
    logic               zero;
`ifdef ACC_CHAIN_EN
    logic               chain_r;
`endif

    logic               busy;
    logic [WIDTH-1:0]   opa;
    logic [WIDTH-1:0]   sum;
    logic [WIDTH-1:0]   diff;
    logic [3:0]         shamt;
    logic [2*WIDTH-1:0] shl_ext;
    logic [WIDTH-1:0]   res_next;
    logic               ovf_next;

    assign busy  = (state == S_T0) || (state == S_T1) || (state == S_T2);
    assign BUSY  = busy;
    assign DONE  = (state == S_DN);
    assign T     = {state == S_DN, state == S_T2, state == S_T1, state == S_T0};
    assign ENTRY = entry;
    assign AC    = ac;
    assign OVF   = ovf;
    assign ZERO  = zero;

    assign opa   = work_a[WIDTH-1:0];
    assign sum   = opa + work_b;
    assign diff  = opa - work_b;
    assign shamt = work_b[3:0];

    always_comb begin
        res_next = ac;
        ovf_next = 1'b0;
        shl_ext  = '0;
        case (op_r)
            OP_ADD: begin
                res_next = sum;
                ovf_next = (opa[WIDTH-1] == work_b[WIDTH-1]) && (sum[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_SUB: begin
                res_next = diff;
                ovf_next = (opa[WIDTH-1] != work_b[WIDTH-1]) && (diff[WIDTH-1] != opa[WIDTH-1]);
            end
            OP_AND: res_next = opa & work_b;
            OP_OR:  res_next = opa | work_b;
            OP_XOR: res_next = opa ^ work_b;
            OP_SHL: begin
                // Shift amounts reaching WIDTH push every bit of A out.
                if (int'(shamt) >= WIDTH) begin
                    res_next = '0;
                    ovf_next = |opa;
                end else begin
                    shl_ext  = {{WIDTH{1'b0}}, opa} << shamt;
                    res_next = shl_ext[WIDTH-1:0];
                    ovf_next = |shl_ext[2*WIDTH-1:WIDTH];
                end
            end
            OP_CLR: res_next = '0;
            default: begin
                res_next = ac;
                ovf_next = 1'b0;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state  <= S_IDLE;
            entry  <= '0;
            reg_a  <= '0;
            reg_b  <= '0;
            op_r   <= '0;
            work_a <= '0;
            work_b <= '0;
            prod   <= '0;
            cnt    <= '0;
            res_r  <= '0;
            ovf_r  <= 1'b0;
            ac     <= '0;
            ovf    <= 1'b0;
            zero   <= 1'b0;
`ifdef ACC_CHAIN_EN
            chain_r <= 1'b0;
`endif
        end else begin
            if (NIB_SHIFT) entry <= {entry[WIDTH-5:0], NIB_IN};
            // Loads see the pre-shift entry value through non-blocking semantics.
            if (!busy) begin
                if (LD1) reg_a <= entry;
                if (LD2) reg_b <= entry;
            end
            case (state)
                S_IDLE: begin
                    if (START) begin
                        op_r  <= OP;
`ifdef ACC_CHAIN_EN
                        chain_r <= CHAIN;
`endif
                        state <= S_T0;
                    end
                end
                S_T0: begin
`ifdef ACC_CHAIN_EN
                    work_a <= {{WIDTH{1'b0}}, (chain_r ? ac : reg_a)};
`else
                    work_a <= {{WIDTH{1'b0}}, reg_a};
`endif
                    work_b <= reg_b;
                    prod   <= '0;
                    cnt    <= CW'(WIDTH - 1);
                    state  <= S_T1;
                end
                S_T1: begin
                    if (op_r == OP_MUL) begin
                        // Shift-add multiply, one multiplier bit per cycle.
                        if (work_b[0]) prod <= prod + work_a;
                        work_a <= work_a << 1;
                        work_b <= work_b >> 1;
                        if (cnt == '0) state <= S_T2;
                        else           cnt   <= cnt - CW'(1);
                    end else begin
                        res_r <= res_next;
                        ovf_r <= ovf_next;
                        state <= S_T2;
                    end
                end
                S_T2: begin
                    if (op_r == OP_MUL) begin
                        ac   <= prod[WIDTH-1:0];
                        ovf  <= |prod[2*WIDTH-1:WIDTH];
                        zero <= (prod[WIDTH-1:0] == '0);
                    end else begin
                        ac   <= res_r;
                        ovf  <= ovf_r;
                        zero <= (res_r == '0);
                    end
                    state <= S_DN;
                end
                S_DN:    state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_acc_exec_seq.sv
// Scoreboard bench for acc_exec_seq at WIDTH=16; chained-operation checks build only with ACC_CHAIN_EN.
module tb_acc_exec_seq;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [3:0]    nib = 4'h0;
    logic          nib_shift = 1'b0;
    logic          ld1 = 1'b0;
    logic          ld2 = 1'b0;
    logic [2:0]    op = 3'd0;
    logic          start = 1'b0;
    logic          chain = 1'b0;
    logic [W-1:0]  entry;
    logic [W-1:0]  ac;
    logic          busy;
    logic          done;
    logic          ovf;
    logic          zero;
    logic [3:0]    t;

    acc_exec_seq #(.WIDTH(W), .OPW(3)) dut (
        .CLK(clk),
        .RST_N(rst_n),
        .NIB_IN(nib),
        .NIB_SHIFT(nib_shift),
        .LD1(ld1),
        .LD2(ld2),
        .OP(op),
        .START(start),
`ifdef ACC_CHAIN_EN
        .CHAIN(chain),
`endif
        .ENTRY(entry),
        .AC(ac),
        .BUSY(busy),
        .DONE(done),
        .OVF(ovf),
        .ZERO(zero),
        .T(t)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] ac;
        logic         ovf;
        logic         zero;
        int           lat;
        int           busy;
    } exp_t;

    exp_t sb[$];
    int nchk = 0;
    int nerr = 0;
    int cyc = 0;
    int start_edge = 0;
    int busy_cnt = 0;
    int done_cnt = 0;
    logic [W-1:0] ma = '0, mb = '0, mac = '0, me = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic exp_t model(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t e;
        logic [31:0] wide;
        e.ovf  = 1'b0;
        e.lat  = 4;
        e.busy = 3;
        case (o)
            3'd0: begin e.ac = a + b; e.ovf = (a[15] == b[15]) && (e.ac[15] != a[15]); end
            3'd1: begin e.ac = a - b; e.ovf = (a[15] != b[15]) && (e.ac[15] != a[15]); end
            3'd2: e.ac = a & b;
            3'd3: e.ac = a | b;
            3'd4: e.ac = a ^ b;
            3'd5: begin wide = {16'h0, a} << b[3:0]; e.ac = wide[15:0]; e.ovf = |wide[31:16]; end
            3'd6: begin
                wide = 32'(a) * 32'(b);
                e.ac = wide[15:0]; e.ovf = |wide[31:16];
                e.lat = W + 3; e.busy = W + 2;
            end
            default: e.ac = '0;
        endcase
        e.zero = (e.ac == '0);
        return e;
    endfunction

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin : monitor
        exp_t e;
        if (busy) busy_cnt++;
        if (done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", {31'b0, done}, 32'd0);
            end else begin
                e = sb.pop_front();
                check("ac", {16'b0, ac}, {16'b0, e.ac});
                check("ovf", {31'b0, ovf}, {31'b0, e.ovf});
                check("zero", {31'b0, zero}, {31'b0, e.zero});
                check("done_latency", cyc - start_edge + 1, e.lat);
                check("busy_cycles", busy_cnt, e.busy);
                check("t_done", {28'b0, t}, 32'h8);
            end
        end
    end

    task automatic shift_nib(input logic [3:0] n);
        nib = n;
        nib_shift = 1'b1;
        me = {me[W-5:0], n};
        @(negedge clk);
        nib_shift = 1'b0;
    endtask

    task automatic load(input logic [W-1:0] v, input bit to_b);
        for (int i = 3; i >= 0; i--) shift_nib(v[4*i +: 4]);
        if (to_b) begin ld2 = 1'b1; mb = me; end
        else      begin ld1 = 1'b1; ma = me; end
        @(negedge clk);
        ld1 = 1'b0;
        ld2 = 1'b0;
    endtask

    task automatic start_op(input logic [2:0] o, input bit ch);
        exp_t e;
        e = model(o, ch ? mac : ma, mb);
        sb.push_back(e);
        mac = e.ac;
        op = o;
        chain = ch;
        start = 1'b1;
        start_edge = cyc + 1;
        busy_cnt = 0;
        @(negedge clk);
        start = 1'b0;
        chain = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n = 0;
        while (sb.size() != 0 && n < bound) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", sb.size(), 0);
        sb.delete();
        @(negedge clk);
    endtask

    task automatic run(input logic [2:0] o, input logic [W-1:0] a, input logic [W-1:0] b);
        load(a, 1'b0);
        load(b, 1'b1);
        start_op(o, 1'b0);
        wait_done(40);
    endtask

    initial begin : stim
        int dc;
        int n;
        repeat (3) @(negedge clk);
        check("rst_ac", {16'b0, ac}, 32'd0);
        check("rst_entry", {16'b0, entry}, 32'd0);
        check("rst_busy", {31'b0, busy}, 32'd0);
        check("rst_done", {31'b0, done}, 32'd0);
        check("rst_t", {28'b0, t}, 32'd0);
        check("rst_flags", {30'b0, ovf, zero}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        load(16'h1234, 1'b0);
        load(16'h0FFF, 1'b1);
        check("entry_display", {16'b0, entry}, 32'h0FFF);
        start_op(3'd0, 1'b0);
        wait_done(20);

        run(3'd0, 16'h7FFF, 16'h0001);
        run(3'd1, 16'h0005, 16'h0005);
        run(3'd1, 16'h8000, 16'h0001);
        run(3'd6, 16'h0012, 16'h0034);
        run(3'd6, 16'h0100, 16'h0100);
        run(3'd2, 16'hF0F0, 16'h0FF0);
        run(3'd3, 16'hF0F0, 16'h0FF0);
        run(3'd4, 16'hF0F0, 16'h0FF0);
        run(3'd5, 16'h8001, 16'h0001);
        run(3'd5, 16'h0003, 16'h000E);
        run(3'd7, 16'h1234, 16'h5678);
        for (int i = 0; i < 6; i++)
            run(3'($urandom_range(0, 7)), 16'($urandom), 16'($urandom));

        // LD in the same cycle as a shift must capture the old entry.
        load(16'h0009, 1'b1);
        load(16'h0011, 1'b0);
        nib = 4'h5; nib_shift = 1'b1; ld1 = 1'b1;
        ma = me; me = {me[W-5:0], 4'h5};
        @(negedge clk);
        nib_shift = 1'b0; ld1 = 1'b0;
        check("entry_after_shift", {16'b0, entry}, {16'b0, me});
        start_op(3'd0, 1'b0);
        wait_done(20);

        // START and LD1 during BUSY are ignored; shifting still works.
        load(16'h0003, 1'b0);
        load(16'h0004, 1'b1);
        dc = done_cnt;
        start_op(3'd0, 1'b0);
        shift_nib(4'hA);
        start = 1'b1; ld1 = 1'b1;
        shift_nib(4'hA);
        start = 1'b0; ld1 = 1'b0;
        shift_nib(4'hA);
        shift_nib(4'hA);
        wait_done(20);
        repeat (6) @(negedge clk);
        check("busy_done_count", done_cnt - dc, 1);
        check("entry_busy_shift", {16'b0, entry}, 32'hAAAA);
        start_op(3'd0, 1'b0);
        wait_done(20);

        // START in the DONE cycle is ignored.
        dc = done_cnt;
        start_op(3'd1, 1'b0);
        n = 0;
        while (!done && n < 20) begin @(negedge clk); n++; end
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (8) @(negedge clk);
        check("done_cycle_start", done_cnt - dc, 1);
        check("sb_empty", sb.size(), 0);

        // Reset in the middle of T1 of a MUL abandons it silently.
        load(16'h0012, 1'b0);
        load(16'h0034, 1'b1);
        dc = done_cnt;
        start_op(3'd6, 1'b0);
        repeat (5) @(negedge clk);
        check("t1_active", {28'b0, t}, 32'h2);
        rst_n = 1'b0;
        @(negedge clk);
        sb.delete();
        check("midrst_ac", {16'b0, ac}, 32'd0);
        check("midrst_busy", {31'b0, busy}, 32'd0);
        check("midrst_t", {28'b0, t}, 32'd0);
        check("midrst_entry", {16'b0, entry}, 32'd0);
        rst_n = 1'b1;
        ma = '0; mb = '0; mac = '0; me = '0;
        repeat (W + 8) @(negedge clk);
        check("midrst_no_done", done_cnt - dc, 0);

`ifdef ACC_CHAIN_EN
        run(3'd0, 16'h0001, 16'h0002);
        start_op(3'd0, 1'b1);
        wait_done(20);
        check("chain_first", {16'b0, ac}, 32'h0005);
        start_op(3'd0, 1'b1);
        wait_done(20);
        check("chain_second", {16'b0, ac}, 32'h0007);
`endif

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/acc_exec_seq.md
Name: acc_exec_seq

Overview:
- Parametrised multi-cycle accumulator execution unit; next generation of the fixed 16-bit, 4-button instruction/accumulator path.
- Operands are entered one hex nibble at a time into an entry register, then latched into operand registers A/B via LD1/LD2.
- A START pulse runs a timed T0/T1/T2 sequence that writes AC and the flags.
- AC feeds the hex display decoders downstream; T[] exposes the one-hot timing signal for debug LEDs.

Parameters:
- WIDTH, 16, datapath width in bits; must be a multiple of 4 and at least 8.
- OPW, 3, opcode width; fixed encoding below, upper opcode values beyond 7 decode as NOP.

Ports:
- CLK  input  1  system clock, rising edge
- RST_N  input  1  synchronous active-low reset
- NIB_IN  input  4  hex digit from the input switches
- NIB_SHIFT  input  1  entry <= {entry[WIDTH-5:0], NIB_IN}
- LD1  input  1  A <= entry
- LD2  input  1  B <= entry
- OP  input  OPW  operation select, sampled at START
- START  input  1  begin operation
- ENTRY  output  WIDTH  current entry register, for display
- AC  output  WIDTH  accumulator
- BUSY  output  1  operation in progress
- DONE  output  1  one-cycle pulse when AC/flags updated
- OVF  output  1  overflow flag
- ZERO  output  1  result==0 flag
- T  output  4  one-hot timing: T[0]=T0, T[1]=T1, T[2]=T2, T[3]=DONE cycle

Behaviour:
- Reset (RST_N=0 at a CLK edge):
  - entry, A, B, AC, OVF, ZERO, DONE, BUSY, T all cleared; FSM to IDLE.
  - Applies mid-operation: the in-flight op is abandoned, with no DONE.
- Entry register:
  - Independent of the FSM; NIB_SHIFT is honoured even while BUSY.
  - If NIB_SHIFT and LD1/LD2 occur in the same cycle, the LD captures the pre-shift entry.
- LD1/LD2:
  - Ignored while BUSY.
  - Both asserted in the same cycle loads A and B with the same value.
- Opcodes:
  - 000 ADD: A+B
  - 001 SUB: A-B
  - 010 AND
  - 011 OR
  - 100 XOR
  - 101 SHL: A<<B[3:0]
  - 110 MUL: low WIDTH bits of A*B
  - 111 CLR: AC=0
- FSM states: IDLE -> T0 -> T1 -> T2 -> DONE -> IDLE.
  - IDLE: START=1 latches OP and moves to T0. START while BUSY is ignored, not queued.
  - T0: copy A, B into working registers.
  - T1: compute. Non-MUL ops take 1 cycle. MUL is shift-add, 1 bit/cycle, so T1 lasts WIDTH cycles using an internal counter.
  - T2: write AC and flags.
  - DONE: DONE=1 and T[3]=1 for exactly one cycle; returns to IDLE. START in this cycle is ignored.
- Latency and handshake:
  - START sampled at edge k gives BUSY=1 for cycles k+1..k+3 (non-MUL) and DONE=1 at cycle k+4.
  - MUL: BUSY spans k+1..k+2+WIDTH, DONE at k+3+WIDTH.
  - BUSY=1 in T0, T1 and T2 only.
- Flags, updated only in T2; held otherwise:
  - ADD/SUB: OVF = two's-complement signed overflow.
  - MUL: OVF = 1 if the high WIDTH bits of the full product are nonzero.
  - SHL: OVF = 1 if any 1 bit is shifted out.
  - Logic ops and CLR: OVF = 0.
  - ZERO = (new AC == 0), for all ops.
- Widths and values:
  - All arithmetic is modulo 2^WIDTH.
  - B[3:0] shift amounts >= WIDTH give AC = 0.

Optional Feature:
- Macro ACC_CHAIN_EN.
- Defined:
  - Adds input port CHAIN (1 bit), sampled with START.
  - CHAIN=1 makes T0 use AC instead of A as the first operand, enabling chained operations (e.g. repeated ADD accumulates B).
- Undefined:
  - No CHAIN port; the first operand is always A.

Test Plan (WIDTH=16):
- Shift 1,2,3,4 then LD1; shift 0,F,F,F then LD2; OP=ADD, START -> ENTRY=0x0FFF, AC=0x2233 with DONE at exactly k+4, OVF=0, ZERO=0.
- A=0x7FFF, B=0x0001, ADD -> AC=0x8000, OVF=1. Then A=0x0005, B=0x0005, SUB -> AC=0x0000, ZERO=1, OVF=0.
- A=0x0012, B=0x0034, MUL -> AC=0x03A8, BUSY high 18 cycles, DONE at k+19. A=0x0100, B=0x0100, MUL -> AC=0x0000, OVF=1, ZERO=1.
- During BUSY: pulse START, LD1 with entry=0xAAAA -> the op completes unaffected, A unchanged, and only one DONE pulse occurs.
- Start MUL, assert RST_N=0 at T1 cycle 5 -> next cycle AC=0, BUSY=0, T=0, and no DONE pulse follows.
- With ACC_CHAIN_EN: AC=0x0003, B=0x0002, ADD with CHAIN=1, run twice -> AC=0x0005, then 0x0007.
